decode_issue_ctrl: RTL and testbench

Issue-gating controller between the decode pipeline stage and rename/map table. Passes decoded uops through at zero latency and enforces the in-order rules the backend cannot: an in-flight limit, full serialization of `UOP_CSR`, and drain-then-trap for illegal instructions. Tracks in-flight uops from issue and commit events and owns the trap request to the front-end redirect logic.

---
 rtl/decode_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Issue gate between decode and rename: zero-latency pass-through with an
// in-flight limit, CSR serialization and drain-then-trap on illegal uops.
package decode_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    UOP_ALU,
    UOP_LOAD,
    UOP_STORE,
    UOP_BRANCH,
    UOP_CSR,
    UOP_MUL,
    UOP_FENCE,
    UOP_NOP
  } uop_t;

  typedef struct packed {
    uop_t            uop;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
  } decoded_t;
endpackage

module decode_issue_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MAX_INFLIGHT = 16,
  localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1),
  localparam int unsigned DEC_W       = $bits(decode_pkg::decoded_t)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [DEC_W-1:0] dec_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DEC_W-1:0] dec_o,
  input  logic             commit_i,
  input  logic             flush_i,
  output logic             trap_valid_o,
  output logic [XLEN-1:0]  trap_pc_o,
  output logic [CNT_W-1:0] inflight_o
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SERIAL = 2'd2;
  localparam logic [1:0] TRAP   = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  trap_pc_q;
  logic             valid_c, ready_c, trap_take;
  logic             cnt_zero, below_max, is_illegal, is_csr;
  logic             fire, dec_cnt;

  decode_pkg::decoded_t dec_s;

  assign dec_s      = dec_i;
  assign dec_o      = dec_s;
  assign is_illegal = dec_s.illegal;
  assign is_csr     = !dec_s.illegal && (dec_s.uop == decode_pkg::UOP_CSR);
  assign cnt_zero   = (cnt_q == '0);
  assign below_max  = (cnt_q < MAX_CNT);

  always_comb begin
    state_d   = state_q;
    valid_c   = 1'b0;
    ready_c   = 1'b0;
    trap_take = 1'b0;
    if (flush_i) begin
      // Flush discards whatever sits at the decode head.
      ready_c = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (is_illegal) begin
            if (cnt_zero) begin
              ready_c = 1'b1;
              if (dec_valid_i) begin
                trap_take = 1'b1;
                state_d   = TRAP;
              end
            end else if (dec_valid_i) begin
              state_d = DRAIN;
            end
          end else if (is_csr) begin
            if (cnt_zero) begin
              valid_c = dec_valid_i;
              ready_c = ready_i;
              if (dec_valid_i && ready_i) state_d = SERIAL;
            end else if (dec_valid_i) begin
              state_d = DRAIN;
            end
          end else begin
            valid_c = dec_valid_i && below_max;
            ready_c = ready_i && below_max;
          end
        end
        DRAIN, SERIAL: begin
          if (cnt_zero) state_d = RUN;
        end
        TRAP: begin
          state_d = TRAP;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign valid_o     = valid_c && !rst_i;
  assign dec_ready_o = ready_c && !rst_i;
  assign fire        = valid_o && ready_i;
  assign dec_cnt     = commit_i && !cnt_zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      trap_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        cnt_q <= '0;
      end else if (fire && !dec_cnt) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!fire && dec_cnt) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (trap_take) trap_pc_q <= XLEN'(dec_s.pc);
    end
  end

  assign trap_valid_o = (state_q == TRAP);
  assign trap_pc_o    = trap_pc_q;
  assign inflight_o   = cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed scenarios plus random
// traffic checked against a transaction-level model of the issue rules.
module tb_decode_issue_ctrl;
  localparam int unsigned MAXI = 4;
  localparam int unsigned CW   = $clog2(MAXI + 1);
  localparam int unsigned DW   = $bits(decode_pkg::decoded_t);

  logic          clk, rst_i;
  logic          dec_valid_i, dec_ready_o, valid_o, ready_i;
  logic [DW-1:0] dec_i, dec_o;
  logic          commit_i, flush_i, trap_valid_o;
  logic [31:0]   trap_pc_o;
  logic [CW-1:0] inflight_o;

  decode_issue_ctrl #(.XLEN(32), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i(clk), .rst_i(rst_i), .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_i(dec_i), .valid_o(valid_o), .ready_i(ready_i), .dec_o(dec_o),
    .commit_i(commit_i), .flush_i(flush_i), .trap_valid_o(trap_valid_o),
    .trap_pc_o(trap_pc_o), .inflight_o(inflight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        r;
    logic        tv;
    logic [31:0] tpc;
    int          n;
  } st_t;

  st_t           stq[$];
  logic [DW-1:0] iq[$];
  st_t           mon_s;

  int tests = 0, fails = 0, dut_fires = 0, peak = 0;

  // Model: outstanding count, a "hold issue until empty" flag, trap flag.
  int          m_n;
  bit          m_wait, m_trap;
  logic [31:0] m_tpc;

  function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_n = 0; m_wait = 0; m_trap = 0; m_tpc = '0;
  endfunction

  function automatic logic [DW-1:0] mk(decode_pkg::uop_t u, logic ill, logic [31:0] pc);
    decode_pkg::decoded_t t;
    t.uop = u; t.illegal = ill; t.pc = pc; t.rd = pc[6:2];
    return t;
  endfunction

  function automatic logic [DW-1:0] rand_dec();
    int unsigned r;
    decode_pkg::uop_t u;
    r = $urandom_range(0, 15);
    case ($urandom_range(0, 4))
      0: u = decode_pkg::UOP_ALU;
      1: u = decode_pkg::UOP_LOAD;
      2: u = decode_pkg::UOP_STORE;
      3: u = decode_pkg::UOP_BRANCH;
      default: u = decode_pkg::UOP_MUL;
    endcase
    if (r == 0) return mk(u, 1'b1, {$urandom} & 32'hFFFF_FFFC);
    if (r < 3)  return mk(decode_pkg::UOP_CSR, 1'b0, {$urandom} & 32'hFFFF_FFFC);
    return mk(u, 1'b0, {$urandom} & 32'hFFFF_FFFC);
  endfunction

  // Called at posedge+1; drives one cycle, records expectations, advances model.
  task automatic step(input logic dv, input logic [DW-1:0] d, input logic rdy,
                      input logic cm, input logic fl, output logic acc);
    decode_pkg::decoded_t ds;
    logic ev, er;
    st_t  s;
    ds = d;
    dec_valid_i = dv; dec_i = d; ready_i = rdy; commit_i = cm; flush_i = fl;
    ev = 1'b0; er = 1'b0;
    s.tv = m_trap; s.tpc = m_tpc; s.n = m_n;
    if (fl) begin
      er = 1'b1;
    end else if (m_trap) begin
      er = 1'b0;
    end else if (m_wait) begin
      if (m_n == 0) m_wait = 0;
    end else if (ds.illegal) begin
      if (m_n == 0) begin
        er = 1'b1;
        if (dv) begin m_trap = 1; m_tpc = ds.pc; end
      end else if (dv) m_wait = 1;
    end else if (ds.uop == decode_pkg::UOP_CSR) begin
      if (m_n == 0) begin
        ev = dv; er = rdy;
        if (dv && rdy) m_wait = 1;
      end else if (dv) m_wait = 1;
    end else begin
      ev = dv && (m_n < MAXI);
      er = rdy && (m_n < MAXI);
    end
    s.v = ev; s.r = er;
    stq.push_back(s);
    if (ev && rdy) iq.push_back(d);
    if (fl) begin
      m_n = 0; m_wait = 0; m_trap = 0;
    end else begin
      m_n = m_n + ((ev && rdy) ? 1 : 0) - ((cm && m_n > 0) ? 1 : 0);
    end
    acc = dv && er;
    @(posedge clk); #1;
    if (int'(inflight_o) > peak) peak = int'(inflight_o);
  endtask

  always @(negedge clk) begin
    if (stq.size() != 0) begin
      mon_s = stq.pop_front();
      chk("valid_o", valid_o, mon_s.v);
      chk("dec_ready_o", dec_ready_o, mon_s.r);
      chk("inflight_o", inflight_o, mon_s.n);
      chk("trap_valid_o", trap_valid_o, mon_s.tv);
      chk("trap_pc_o", trap_pc_o, mon_s.tpc);
      if (valid_o && ready_i) begin
        dut_fires++;
        if (iq.size() == 0) begin
          tests++; fails++;
          $display("FAIL issue actual=unexpected_fire required=no_fire @%0t", $time);
        end else begin
          chk("dec_o", dec_o, iq.pop_front());
        end
      end
    end
  end

  logic [DW-1:0] nrm, csr, ill, cur;
  logic acc;
  int f0;

  initial begin
    dec_valid_i = 0; dec_i = '0; ready_i = 0; commit_i = 0; flush_i = 0;
    rst_i = 1; model_reset();
    nrm = mk(decode_pkg::UOP_ALU, 1'b0, 32'h0000_0100);
    csr = mk(decode_pkg::UOP_CSR, 1'b0, 32'h0000_0200);
    ill = mk(decode_pkg::UOP_LOAD, 1'b1, 32'h0000_0104);
    repeat (3) @(posedge clk);
    #1 rst_i = 0;

    step(0, nrm, 1, 0, 0, acc);

    // Streaming with commits three cycles behind issue.
    peak = 0; f0 = dut_fires;
    for (int i = 0; i < 23; i++) step(i < 20, nrm, 1, i >= 3, 0, acc);
    step(0, nrm, 1, 0, 0, acc);
    chk("stream_fires", dut_fires - f0, 20);
    chk("stream_peak", peak, 3);

    // In-flight limit.
    f0 = dut_fires;
    for (int i = 0; i < 6; i++) step(1, nrm, 1, 0, 0, acc);
    chk("limit_fires", dut_fires - f0, 4);
    step(1, nrm, 1, 1, 0, acc);
    step(1, nrm, 1, 0, 0, acc);
    chk("limit_after_commit", dut_fires - f0, 5);
    for (int i = 0; i < 5; i++) step(0, nrm, 1, 1, 0, acc);

    // CSR serialization behind two in-flight uops.
    step(1, nrm, 1, 0, 0, acc);
    step(1, nrm, 1, 0, 0, acc);
    step(1, csr, 1, 0, 0, acc);
    step(1, csr, 1, 0, 0, acc);
    step(1, csr, 1, 1, 0, acc);
    step(1, csr, 1, 1, 0, acc);
    acc = 0;
    for (int i = 0; i < 6 && !acc; i++) step(1, csr, 1, 0, 0, acc);
    for (int i = 0; i < 3; i++) step(1, nrm, 1, 0, 0, acc);
    step(1, nrm, 1, 1, 0, acc);
    acc = 0;
    for (int i = 0; i < 5 && !acc; i++) step(1, nrm, 1, 0, 0, acc);
    step(0, nrm, 1, 1, 0, acc);

    // Illegal behind one in-flight uop, trap held until flush.
    step(1, nrm, 1, 0, 0, acc);
    step(1, ill, 1, 0, 0, acc);
    step(1, ill, 1, 1, 0, acc);
    acc = 0;
    for (int i = 0; i < 4 && !acc; i++) step(1, ill, 1, 0, 0, acc);
    for (int i = 0; i < 10; i++) step(0, nrm, 1, 0, 0, acc);
    chk("trap_pc_held", trap_pc_o, 32'h0000_0104);
    step(0, nrm, 1, 0, 1, acc);
    step(1, nrm, 1, 0, 0, acc);
    step(0, nrm, 1, 1, 0, acc);

    // Flush during SERIAL with a simultaneous commit.
    step(1, csr, 1, 0, 0, acc);
    step(1, nrm, 1, 0, 0, acc);
    step(1, nrm, 1, 1, 1, acc);
    step(1, nrm, 1, 0, 0, acc);
    step(0, nrm, 1, 1, 0, acc);

    // Asynchronous reset while draining.
    step(1, nrm, 1, 0, 0, acc);
    step(1, nrm, 1, 0, 0, acc);
    step(1, csr, 1, 0, 0, acc);
    #2 rst_i = 1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", dec_ready_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_trap", trap_valid_o, 0);
    model_reset();
    @(posedge clk); #1 rst_i = 0;
    step(0, nrm, 1, 1, 0, acc);
    step(0, nrm, 1, 0, 0, acc);

    // Random traffic; decode head is held until accepted.
    cur = rand_dec();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, acc);
      if (acc) cur = rand_dec();
    end

    repeat (2) @(posedge clk);
    chk("issue_queue_drained", iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
